// File: rtl/semaphore_pkg.sv
// Shared traffic-light definitions: lamp phase encoding and default phase lengths,
// used by both the semaphore controller and its monitor so the two cannot drift.
package semaphore_pkg;

    typedef enum logic [1:0] {
        PH_DARK   = 2'd0,
        PH_RED    = 2'd1,
        PH_YELLOW = 2'd2,
        PH_GREEN  = 2'd3
    } phase_t;

    localparam int RED_CYCLES_DEF    = 51;
    localparam int YELLOW_CYCLES_DEF = 11;
    localparam int GREEN_CYCLES_DEF  = 31;

    // DARK->RED is the only way into the cycle; the lit phases rotate R->Y->G->R.
    function automatic logic legal_step(input phase_t from_ph, input phase_t to_ph);
        return (from_ph == PH_DARK   && to_ph == PH_RED)    ||
               (from_ph == PH_RED    && to_ph == PH_YELLOW) ||
               (from_ph == PH_YELLOW && to_ph == PH_GREEN)  ||
               (from_ph == PH_GREEN  && to_ph == PH_RED);
    endfunction

endpackage

// File: rtl/semaphore_monitor_if.sv
// Lamp samples into the monitor and decoded phase/statistics/error flags out of it.
// master = lamp driver / observer side, slave = the monitor itself.
interface semaphore_monitor_if #(
    parameter int CNT_W = 8
);
    import semaphore_pkg::*;

    logic             red;
    logic             yellow;
    logic             green;
    logic             clear_err;

    phase_t           phase;
    logic [CNT_W-1:0] phase_len;
    logic             phase_done;
    logic [CNT_W-1:0] last_len;
    logic [15:0]      cycles_done;
    logic             err_onehot;
    logic             err_order;
    logic             err_duration;
    logic             error;

    modport master (
        output red, yellow, green, clear_err,
        input  phase, phase_len, phase_done, last_len, cycles_done,
        input  err_onehot, err_order, err_duration, error
    );

    modport slave (
        input  red, yellow, green, clear_err,
        output phase, phase_len, phase_done, last_len, cycles_done,
        output err_onehot, err_order, err_duration, error
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-1 (clear > load > inc).
// Latency: 1 cycle; backpressure: none, holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load_one,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load_one) begin
            cnt <= W'(1);
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/semaphore_monitor.sv
// Passive lamp-protocol monitor: decodes phase, measures phase lengths, flags one-hot/order/duration faults.
// Latency: 1 cycle from lamp sample to all outputs; backpressure: none, every sample is consumed.
module semaphore_monitor
    import semaphore_pkg::*;
#(
    parameter int RED_CYCLES    = RED_CYCLES_DEF,
    parameter int YELLOW_CYCLES = YELLOW_CYCLES_DEF,
    parameter int GREEN_CYCLES  = GREEN_CYCLES_DEF,
    parameter int CNT_W         = 8
) (
    input  logic                clk,
    input  logic                reset,
    semaphore_monitor_if.slave  mon
);

    localparam logic [CNT_W-1:0] RED_REQ    = CNT_W'(RED_CYCLES);
    localparam logic [CNT_W-1:0] YELLOW_REQ = CNT_W'(YELLOW_CYCLES);
    localparam logic [CNT_W-1:0] GREEN_REQ  = CNT_W'(GREEN_CYCLES);

    phase_t           phase_q, phase_d, lamp_ph;
    logic [CNT_W-1:0] len_q, last_q, last_d, req_len;
    logic [15:0]      cyc_q, cyc_d;
    logic             done_q, done_d;
    logic             eoh_q, eord_q, edur_q, err_q;
    logic             eoh_d, eord_d, edur_d;
    logic             v_oh, v_ord, v_dur;
    logic             cnt_clr, cnt_load, cnt_inc;
    logic             is_dark, is_multi;

    assign is_dark  = ~(mon.red | mon.yellow | mon.green);
    assign is_multi = (mon.red & mon.yellow) | (mon.red & mon.green) | (mon.yellow & mon.green);

    always_comb begin
        lamp_ph = PH_GREEN;
        if (mon.red) begin
            lamp_ph = PH_RED;
        end else if (mon.yellow) begin
            lamp_ph = PH_YELLOW;
        end
    end

    always_comb begin
        case (phase_q)
            PH_RED:    req_len = RED_REQ;
            PH_YELLOW: req_len = YELLOW_REQ;
            PH_GREEN:  req_len = GREEN_REQ;
            default:   req_len = '0;
        endcase
    end

    always_comb begin
        phase_d  = phase_q;
        done_d   = 1'b0;
        last_d   = last_q;
        cyc_d    = cyc_q;
        v_oh     = 1'b0;
        v_ord    = 1'b0;
        v_dur    = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;

        if (is_multi) begin
            v_oh = 1'b1;
        end else if (is_dark) begin
            // Controller disabled mid-phase: report the partial length, skip checks.
            if (phase_q != PH_DARK) begin
                done_d  = 1'b1;
                last_d  = len_q;
                phase_d = PH_DARK;
                cnt_clr = 1'b1;
            end
        end else if (lamp_ph == phase_q) begin
            cnt_inc = 1'b1;
            // Equality before the increment catches only the first excess sample.
            if (len_q == req_len) begin
                v_dur = 1'b1;
            end
        end else begin
            if (phase_q != PH_DARK) begin
                done_d = 1'b1;
                last_d = len_q;
                if (len_q < req_len) begin
                    v_dur = 1'b1;
                end
            end
            if (!legal_step(phase_q, lamp_ph)) begin
                v_ord = 1'b1;
            end
            if (phase_q == PH_GREEN && lamp_ph == PH_RED) begin
                cyc_d = cyc_q + 16'd1;
            end
            phase_d  = lamp_ph;
            cnt_load = 1'b1;
        end

        eoh_d  = (eoh_q  & ~mon.clear_err) | v_oh;
        eord_d = (eord_q & ~mon.clear_err) | v_ord;
        edur_d = (edur_q & ~mon.clear_err) | v_dur;
    end

    sat_counter #(
        .W (CNT_W)
    ) u_phase_len (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .load_one (cnt_load),
        .inc      (cnt_inc),
        .cnt      (len_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= PH_DARK;
            done_q  <= 1'b0;
            last_q  <= '0;
            cyc_q   <= '0;
            eoh_q   <= 1'b0;
            eord_q  <= 1'b0;
            edur_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            done_q  <= done_d;
            last_q  <= last_d;
            cyc_q   <= cyc_d;
            eoh_q   <= eoh_d;
            eord_q  <= eord_d;
            edur_q  <= edur_d;
            err_q   <= eoh_d | eord_d | edur_d;
        end
    end

    assign mon.phase        = phase_q;
    assign mon.phase_len    = len_q;
    assign mon.phase_done   = done_q;
    assign mon.last_len     = last_q;
    assign mon.cycles_done  = cyc_q;
    assign mon.err_onehot   = eoh_q;
    assign mon.err_order    = eord_q;
    assign mon.err_duration = edur_q;
    assign mon.error        = err_q;

endmodule

// File: tb/tb_semaphore_monitor.sv
// Directed-vector bench for semaphore_monitor: stimulus queues hand-computed
// expectations, a monitor process pops one per output update and compares.
module tb_semaphore_monitor;

    localparam logic [2:0] L_D = 3'b000;
    localparam logic [2:0] L_R = 3'b100;
    localparam logic [2:0] L_Y = 3'b010;
    localparam logic [2:0] L_G = 3'b001;

    typedef struct {
        int    ph, len, dn, lst, cyc, eoh, eord, edur, err;
        string tag;
    } exp_t;

    logic clk;
    logic reset;
    bit   stim_done;
    int   n_vec;
    int   n_mis;
    exp_t exp_q[$];

    semaphore_monitor_if #(.CNT_W(8)) bus ();

    semaphore_monitor #(
        .RED_CYCLES    (51),
        .YELLOW_CYCLES (11),
        .GREEN_CYCLES  (31),
        .CNT_W         (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (bus)
    );

    always #5 clk = ~clk;

    function automatic void cmp(input string tag, input string fld, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_mis++;
            $display("FAIL %s.%s: got %0d, want %0d", tag, fld, act, expv);
        end
    endfunction

    task automatic push_exp(input int ph, len, dn, lst, cyc, eoh, eord, edur, input string tag);
        exp_t e;
        e.ph = ph; e.len = len; e.dn = dn; e.lst = lst; e.cyc = cyc;
        e.eoh = eoh; e.eord = eord; e.edur = edur;
        e.err = ((eoh | eord | edur) != 0) ? 1 : 0;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [2:0] l, input logic c,
                        input int ph, len, dn, lst, cyc, eoh, eord, edur, input string tag);
        @(negedge clk);
        {bus.red, bus.yellow, bus.green} = l;
        bus.clear_err = c;
        push_exp(ph, len, dn, lst, cyc, eoh, eord, edur, tag);
    endtask

    // n samples of one lamp; phase_len counts 1..n (0 when dark), done only on the first.
    task automatic run(input logic [2:0] l, input int n, input int ph, input int dn_first,
                       input int lst, input int cyc, input int eoh, input int eord, input int edur,
                       input string tag);
        for (int k = 1; k <= n; k++) begin
            step(l, 1'b0, ph, (ph == 0) ? 0 : k, (k == 1) ? dn_first : 0,
                 lst, cyc, eoh, eord, edur, tag);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        {bus.red, bus.yellow, bus.green} = L_D;
        bus.clear_err = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic stimulus();
        @(negedge clk);
        push_exp(0, 0, 0, 0, 0, 0, 0, 0, "reset_state");
        @(negedge clk);
        reset = 1'b0;

        // Golden cycle
        run(L_D, 3,  0, 0, 0,  0, 0, 0, 0, "gold_dark");
        run(L_R, 51, 1, 0, 0,  0, 0, 0, 0, "gold_red");
        run(L_Y, 11, 2, 1, 51, 0, 0, 0, 0, "gold_yel");
        run(L_G, 31, 3, 1, 11, 0, 0, 0, 0, "gold_grn");
        run(L_R, 5,  1, 1, 31, 1, 0, 0, 0, "gold_red2");

        // Short yellow
        do_reset();
        run(L_R, 51, 1, 0, 0,  0, 0, 0, 0, "sy_red");
        run(L_Y, 10, 2, 1, 51, 0, 0, 0, 0, "sy_yel");
        step(L_G, 1'b0, 3, 1, 1, 10, 0, 0, 0, 1, "sy_underrun");
        step(L_G, 1'b0, 3, 2, 0, 10, 0, 0, 0, 1, "sy_sticky");

        // Long red, then clear shows no re-flag
        do_reset();
        run(L_R, 51, 1, 0, 0, 0, 0, 0, 0, "lr_red");
        step(L_R, 1'b0, 1, 52, 0, 0, 0, 0, 0, 1, "lr_overrun");
        step(L_R, 1'b1, 1, 53, 0, 0, 0, 0, 0, 0, "lr_clear");
        step(L_R, 1'b0, 1, 54, 0, 0, 0, 0, 0, 0, "lr_no_reflag");

        // Order violation
        do_reset();
        run(L_R, 51, 1, 0, 0, 0, 0, 0, 0, "ord_red");
        step(L_G, 1'b0, 3, 1, 1, 51, 0, 0, 1, 0, "ord_r2g");

        // One-hot violation holds phase state
        do_reset();
        run(L_R, 5, 1, 0, 0, 0, 0, 0, 0, "oh_red");
        step(L_R | L_G, 1'b0, 1, 5, 0, 0, 0, 1, 0, 0, "oh_multi");
        step(L_R,       1'b0, 1, 6, 0, 0, 0, 1, 0, 0, "oh_resume");

        // Disable mid-green
        do_reset();
        run(L_R, 51, 1, 0, 0,  0, 0, 0, 0, "dis_red");
        run(L_Y, 11, 2, 1, 51, 0, 0, 0, 0, "dis_yel");
        run(L_G, 15, 3, 1, 11, 0, 0, 0, 0, "dis_grn");
        step(L_D, 1'b0, 0, 0, 1, 15, 0, 0, 0, 0, "dis_dark");
        run(L_D, 3, 0, 0, 15, 0, 0, 0, 0, "dis_dark_hold");
        step(L_Y, 1'b0, 2, 1, 0, 15, 0, 0, 1, 0, "dis_yel_order");

        // Clear concurrent with overrun: violation wins, other flags cleared
        do_reset();
        run(L_R, 50, 1, 0, 0, 0, 0, 0, 0, "clr_red");
        step(L_R | L_Y, 1'b0, 1, 50, 0, 0, 0, 1, 0, 0, "clr_multi");
        step(L_R,       1'b0, 1, 51, 0, 0, 0, 1, 0, 0, "clr_red51");
        step(L_R,       1'b1, 1, 52, 0, 0, 0, 0, 0, 1, "clr_vs_overrun");

        // Asynchronous reset mid-red
        do_reset();
        run(L_R, 20, 1, 0, 0, 0, 0, 0, 0, "ar_red");
        @(posedge clk);
        #3;
        push_exp(0, 0, 0, 0, 0, 0, 0, 0, "async_reset");
        reset = 1'b1;
        @(negedge clk);
        {bus.red, bus.yellow, bus.green} = L_D;
        reset = 1'b0;
        step(L_R, 1'b0, 1, 1, 0, 0, 0, 0, 0, 0, "ar_restart");

        repeat (3) @(posedge clk);
        stim_done = 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        while (!stim_done) begin
            @(posedge clk or posedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.tag, "phase",        int'(bus.phase),        e.ph);
                cmp(e.tag, "phase_len",    int'(bus.phase_len),    e.len);
                cmp(e.tag, "phase_done",   int'(bus.phase_done),   e.dn);
                cmp(e.tag, "last_len",     int'(bus.last_len),     e.lst);
                cmp(e.tag, "cycles_done",  int'(bus.cycles_done),  e.cyc);
                cmp(e.tag, "err_onehot",   int'(bus.err_onehot),   e.eoh);
                cmp(e.tag, "err_order",    int'(bus.err_order),    e.eord);
                cmp(e.tag, "err_duration", int'(bus.err_duration), e.edur);
                cmp(e.tag, "error",        int'(bus.error),        e.err);
            end
        end
    endtask

    initial begin
        clk           = 1'b0;
        reset         = 1'b1;
        stim_done     = 1'b0;
        n_vec         = 0;
        n_mis         = 0;
        bus.red       = 1'b0;
        bus.yellow    = 1'b0;
        bus.green     = 1'b0;
        bus.clear_err = 1'b0;
        fork
            stimulus();
            monitor();
        join
        n_vec++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/semaphore_monitor.md
Name: semaphore_monitor

Overview:
- Passive receive-side monitor for the traffic-light lamp interface (red/yellow/green) driven by the semaphore controller.
- Decodes the current phase, measures each phase length in clock cycles and checks the protocol:
  - exactly one lamp lit or all dark;
  - legal order RED->YELLOW->GREEN->RED;
  - exact phase durations.
- Sits beside the controller in the same clock domain. Used in-system for fault detection and as the bench's scoreboard front end.

Parameters:
- RED_CYCLES, 51, required number of consecutive red-lit samples per RED phase.
- YELLOW_CYCLES, 11, required yellow-lit samples per YELLOW phase.
- GREEN_CYCLES, 31, required green-lit samples per GREEN phase.
- CNT_W, 8, width of phase length counters; must hold max(*_CYCLES)+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- red  in  1  red lamp sample.
- yellow  in  1  yellow lamp sample.
- green  in  1  green lamp sample.
- clear_err  in  1  synchronous clear of all sticky error flags.
- phase  out  2  decoded phase: 0 DARK, 1 RED, 2 YELLOW, 3 GREEN.
- phase_len  out  CNT_W  samples seen in current phase, including the latest one.
- phase_done  out  1  one-cycle pulse when a lit phase ends.
- last_len  out  CNT_W  length of the phase that just ended; valid with phase_done, held otherwise.
- cycles_done  out  16  count of legal GREEN->RED transitions; wraps at 65535->0.
- err_onehot  out  1  sticky: more than one lamp lit in one sample.
- err_order  out  1  sticky: illegal phase transition.
- err_duration  out  1  sticky: phase shorter or longer than required.
- error  out  1  OR of the three sticky flags (registered).

Behaviour:
- All outputs are registered. Reset values: phase=0, phase_len=0, phase_done=0, last_len=0, cycles_done=0, all error flags 0.
- Reset asserted mid-operation clears everything immediately. The first sample after reset is treated as coming from DARK.
- Timing: the lamps are sampled on each rising edge. Outputs reflect that sample after the same edge (1-cycle latency from a lamp change to phase/flags).
- Sample classes: DARK (000), single lamp lit, MULTI (two or more lit).
- MULTI sample:
  - sets err_onehot;
  - phase, phase_len, phase_done and last_len hold;
  - the sample is ignored for order and duration checks.
- Same lit phase as current:
  - phase_len increments, saturating at 2^CNT_W-1.
  - If phase_len already equals the required count before the increment, set err_duration (overrun). This flags only once per phase, on the first excess sample.
- New lit phase (phase changes):
  - previous phase lit: phase_done=1, last_len=old phase_len.
  - previous phase lit and old phase_len < required: set err_duration (underrun).
  - Legal transitions: DARK->RED, RED->YELLOW, YELLOW->GREEN, GREEN->RED. Any other sets err_order.
  - GREEN->RED increments cycles_done.
  - The monitor always resyncs: phase = new lamp, phase_len = 1.
- DARK sample from a lit phase:
  - phase_done=1, last_len=old phase_len;
  - phase=0, phase_len=0;
  - no duration or order check (the controller was disabled mid-phase);
  - the next lit phase must be RED.
- DARK while DARK: no change, phase_len stays 0.
- clear_err=1 clears all sticky flags. If a violation is detected on the same edge, that flag is set (violation wins).
- Counters never wrap silently except cycles_done, which is explicitly a wrapping statistic.

Decomposition:
- Shared package semaphore_pkg holds:
  - the phase encoding constants (DARK/RED/YELLOW/GREEN);
  - the default phase durations 51/11/31, used by both the controller and this monitor so they cannot drift.
- One natural sub-module: sat_counter (CNT_W-wide, sync load-to-1/clear, saturating increment), instantiated for phase_len.

Test Plan:
- Golden sequence: DARK 3, red 51, yellow 11, green 31, red 5 -> phase_done pulses with last_len 51, 11, 31; cycles_done=1; error=0 throughout.
- Short yellow: red 51, yellow 10, green -> err_duration set on the edge sampling the first green; phase=3, phase_len=1.
- Long red: red held 52 samples -> err_duration set on the 52nd red edge; phase_len=52; no further flag events.
- Order and one-hot:
  - red 51 then green -> err_order=1, phase=3.
  - separate run: red+green lit together for 1 sample -> err_onehot=1, phase and phase_len unchanged.
- Disable mid-phase: green 15 then DARK 4 then yellow -> phase_done with last_len=15, no error; yellow then sets err_order.
- Clear and reset:
  - clear_err with a simultaneous overrun -> err_duration remains 1;
  - reset asserted asynchronously mid-RED -> all outputs 0 before the next edge.
